s2p_rx: RTL
===========

Name: s2p_rx

Overview:
- Serial-to-parallel receiver; counterpart of the p2s transmitter.
- Rebuilds W-bit words from a qualified serial bit stream. A start-of-frame strobe marks the first bit of each word.
- Presents each word on a valid/ready output port with a one-word holding register.
- Sits between the serial link and parallel consumers; bench pairs it back-to-back with p2s.

Parameters:
- W, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in pout[W-1]; 0: first bit lands in pout[0].

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- sin  input  1  serial data bit.
- sin_en  input  1  bit strobe; sin is sampled only when high.
- sof  input  1  start of frame; valid only with sin_en, marks the current bit as bit 0.
- pout  output  W  received parallel word, stable while pvalid=1.
- pvalid  output  1  pout holds an unconsumed word.
- pready  input  1  consumer accepts pout when pvalid & pready.
- done  output  1  one-cycle pulse when a word is transferred to pout.
- rdy  output  1  receiver is idle and waiting for sof.
- busy  output  1  frame in progress (SHIFT or PAR).
- ovr  output  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- sync_err  output  1  one-cycle pulse: sof arrived mid-frame.
- perr  output  1  parity error flag attached to the word on pout.

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, bit counter=0, shift register=0, pout=0. Outputs pvalid=0, done=0, ovr=0, sync_err=0, perr=0, busy=0, rdy=1. Any partial frame is discarded.
- IDLE: rdy=1, busy=0.
  - sin_en & sof: shift in sin, cnt=1, go to SHIFT.
  - sin_en without sof: ignored.
- SHIFT: busy=1, rdy=0.
  - sin_en & !sof: shift in sin, cnt++.
  - sin_en low: hold all state; no timeout.
  - sin_en & sof: resync. Pulse sync_err, discard partial word, treat the bit as bit 0, cnt=1, stay in SHIFT.
  - Bit W sampled (cnt reaches W): word complete. Go to PAR if the parity feature is compiled in, else go to IDLE.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into LSB.
  - MSB_FIRST=0: shift right, new bit into MSB.
- Word transfer (on completion):
  - If holding register is empty, or pvalid & pready in the same cycle: load pout, pvalid=1 and done=1 in the cycle after the sampling edge of the last bit. Latency is 1 clock from the last sin_en.
  - If pvalid=1 & !pready: new word dropped, pout unchanged, ovr pulses in that same cycle.
- Output handshake:
  - pvalid stays high until pvalid & pready.
  - pout must not change while pvalid=1 except on the simultaneous accept+load case.
  - pready with pvalid=0 has no effect.
- Back-to-back frames: sin_en & sof may arrive in the clock after the last bit; IDLE accepts it with no gap.
- W counter width is $clog2(W+1); no wrap beyond W.

Optional Feature:
- Macro: S2P_PARITY_EN.
- Defined:
  - After W data bits, FSM enters PAR (busy=1) and takes one extra sin_en bit as the even-parity bit.
  - perr = XOR(data) ^ parity_bit. It is loaded with pout and valid while pvalid=1.
  - sof in PAR: sync_err, restart as in SHIFT.
  - Word transfer happens after the parity bit, not after bit W.
- Undefined: no PAR state, perr tied to 0, word transfers after bit W.

Decomposition:
- Package s2p_pkg:
  - state typedef enum logic [1:0] {IDLE, SHIFT, PAR}.
  - PAR_EVEN constant.
  - Function cnt_w(W) returning the counter width.
- One sub-module, s2p_hold: the valid/ready holding register with ovr generation. It takes load, din, perr_in and produces pout, pvalid, perr.

Test Plan:
- Reset, then with W=4, MSB_FIRST=1 and pready=1, send words 6, 7, 8, 9 back-to-back (sof on the first bit of each) -> pout=6, 7, 8, 9 with one done pulse each, 1 clk after each last bit; no ovr or sync_err.
- Loopback: p2s output → s2p_rx input for words 6..9 -> received words equal transmitted words; rdy=1 between frames.
- pready=0 while two words (0xA, then 0x5) arrive -> pout stays 0xA with pvalid=1; ovr pulses once at the second completion. Raise pready -> pvalid drops the next cycle.
- sof re-asserted after 2 bits of a frame, then 4 clean bits of 0x3 -> sync_err pulses once; pout=0x3.
- Assert rst mid-frame after 3 bits, release, then send 0xC -> all outputs at reset values immediately; pout=0xC only after a fresh frame.
- With S2P_PARITY_EN, send 0x6 with parity bit 0, then 0x6 with parity bit 1 -> perr=0 for the first, perr=1 for the second. Done is 1 clk after the parity bit.

Source files
------------

// File: rtl/s2p_pkg.sv
// ============================================================================
// Module   : s2p_pkg
// Purpose  : Shared types and helpers for the s2p_rx serial-to-parallel
//            receiver (FSM state encoding, parity sense, counter sizing).
// Macros   : S2P_PARITY_EN (consumed by s2p_rx; enables the PAR state)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package s2p_pkg;

    // Receiver FSM states. PAR is only entered when the parity bit is enabled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Parity sense: 0 selects even parity, so perr = XOR(data) ^ parity_bit.
    localparam logic PAR_EVEN = 1'b0;

    // Width of a counter that must hold the values 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/s2p_hold.sv
// ============================================================================
// Module   : s2p_hold
// Purpose  : One-word valid/ready holding register for s2p_rx. Captures a
//            completed word when empty (or being drained this cycle) and
//            flags an overrun when a word arrives while the slot is blocked.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            load          - a completed word is offered this cycle
//            din, perr_in  - offered word and its parity-error flag
//            pready        - consumer accepts pout when pvalid & pready
//            pout, perr    - held word and its parity-error flag
//            pvalid        - pout holds an unconsumed word
//            done          - one-cycle pulse: word captured
//            ovr           - one-cycle pulse: offered word dropped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2p_hold #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         perr_in,
    input  logic         pready,
    output logic [W-1:0] pout,
    output logic         pvalid,
    output logic         perr,
    output logic         done,
    output logic         ovr
);

    logic [W-1:0] r_pout;
    logic         r_pvalid;
    logic         r_perr;
    logic         r_done;
    logic         r_ovr;

    logic w_accept;
    logic w_take;

    // A drain and a load in the same cycle are allowed: the slot frees and
    // refills on the same edge, so the consumer never sees a bubble.
    assign w_accept = r_pvalid & pready;
    assign w_take   = load & (~r_pvalid | pready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pout   <= '0;
            r_pvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_done <= w_take;
            r_ovr  <= load & r_pvalid & ~pready;
            if (w_take) begin
                r_pout   <= din;
                r_perr   <= perr_in;
                r_pvalid <= 1'b1;
            end else if (w_accept) begin
                r_pvalid <= 1'b0;
            end
        end
    end

    assign pout   = r_pout;
    assign pvalid = r_pvalid;
    assign perr   = r_perr;
    assign done   = r_done;
    assign ovr    = r_ovr;

endmodule

`default_nettype wire

// File: rtl/s2p_rx.sv
// ============================================================================
// Module   : s2p_rx
// Purpose  : Serial-to-parallel receiver. Rebuilds W-bit words from a
//            strobed serial stream (sof marks bit 0) and presents them on a
//            valid/ready port through a one-word holding register.
// Macros   : S2P_PARITY_EN - when defined, one extra even-parity bit follows
//            each word and perr reports a mismatch; otherwise perr is 0.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            sin, sin_en, sof   - serial bit, bit strobe, start of frame
//            pout, pvalid       - received word / word held
//            pready             - consumer accept
//            done, ovr          - word captured / word dropped (pulses)
//            rdy, busy          - idle waiting for sof / frame in progress
//            sync_err           - pulse: sof arrived mid-frame
//            perr               - parity error flag travelling with pout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module s2p_rx
    import s2p_pkg::*;
#(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         sof,
    output logic [W-1:0] pout,
    output logic         pvalid,
    input  logic         pready,
    output logic         done,
    output logic         rdy,
    output logic         busy,
    output logic         ovr,
    output logic         sync_err,
    output logic         perr
);

    localparam int            CW     = cnt_w(W);
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sreg;
    logic          r_sync_err;

    logic [W-1:0]  w_shift_data;  // shift register after taking sin
    logic [W-1:0]  w_first_data;  // fresh frame: sin as bit 0, rest cleared
    logic          w_load;
    logic [W-1:0]  w_din;
    logic          w_perr;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_data = {r_sreg[W-2:0], sin};
            assign w_first_data = {{(W-1){1'b0}}, sin};
        end else begin : g_lsb_first
            assign w_shift_data = {sin, r_sreg[W-1:1]};
            assign w_first_data = {sin, {(W-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sreg     <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= sin_en & sof & (r_state != IDLE);
            if (sin_en & sof) begin
                // sof always restarts a frame; mid-frame it also discards the
                // partial word (flagged above as a sync error).
                r_sreg  <= w_first_data;
                r_cnt   <= C_ONE;
                r_state <= SHIFT;
            end else if (sin_en) begin
                case (r_state)
                    SHIFT: begin
                        r_sreg <= w_shift_data;
                        if (r_cnt == C_LAST) begin
`ifdef S2P_PARITY_EN
                            r_state <= PAR;
                            r_cnt   <= r_cnt + 1'b1;
`else
                            r_state <= IDLE;
                            r_cnt   <= '0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PAR: begin
                        // Parity bit consumed; the word leaves via w_load.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                    IDLE: begin
                        // Bits outside a frame are ignored.
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // The holding register captures on the same edge that samples the final
    // bit, giving one clock of latency from the last strobe to pvalid/done.
`ifdef S2P_PARITY_EN
    assign w_load = (r_state == PAR) & sin_en & ~sof;
    assign w_din  = r_sreg;
    assign w_perr = (^r_sreg) ^ sin ^ PAR_EVEN;
`else
    assign w_load = (r_state == SHIFT) & sin_en & ~sof & (r_cnt == C_LAST);
    assign w_din  = w_shift_data;
    assign w_perr = 1'b0;
`endif

    s2p_hold #(
        .W (W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .din     (w_din),
        .perr_in (w_perr),
        .pready  (pready),
        .pout    (pout),
        .pvalid  (pvalid),
        .perr    (perr),
        .done    (done),
        .ovr     (ovr)
    );

    assign rdy      = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign sync_err = r_sync_err;

endmodule

`default_nettype wire
